// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU multi-cycle controller.
// Holds the 4-bit opcode map, the FSM state encoding, the fetch-select
// codes and a helper that identifies the states that wait on mem_ready.
package cpu_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_OPND   = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_JUMP   = 4'd7,
      S_IRQ    = 4'd8,
      S_HALT   = 4'd9,
      S_TRAP   = 4'd10
   } state_t;

   // Opcodes 1100..1110 are unassigned and decode as illegal.
   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_LDO = 4'b0001;
   localparam logic [3:0] OP_LDA = 4'b0010;
   localparam logic [3:0] OP_STO = 4'b0011;
   localparam logic [3:0] OP_PRE = 4'b0100;
   localparam logic [3:0] OP_ADD = 4'b0101;
   localparam logic [3:0] OP_LDM = 4'b0110;
   localparam logic [3:0] OP_JMP = 4'b0111;
   localparam logic [3:0] OP_INC = 4'b1000;
   localparam logic [3:0] OP_DEC = 4'b1001;
   localparam logic [3:0] OP_ADN = 4'b1010;
   localparam logic [3:0] OP_CLR = 4'b1011;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [1:0] FETCH_NONE = 2'b00;
   localparam logic [1:0] FETCH_IR   = 2'b01;
   localparam logic [1:0] FETCH_OPND = 2'b10;

   // States that hold on a ROM/RAM access until mem_ready.
   function automatic logic is_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_OPND) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state watchdog for memory accesses.
// Counts cycles spent without mem_ready and flags expiry on the cycle the
// count would reach MAX_WAIT while ready is still low. MAX_WAIT=0 disables it.
// Ports: clk, rst (async, active high), clear (restart count), ready
// (access complete this cycle), expired (timeout this cycle, combinational).
module mem_wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic ready,
   output logic expired
);

   localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] LIMIT = (MAX_WAIT < 1) ? '0 : CW'(MAX_WAIT - 1);

   logic [CW-1:0] cnt_r;

   // Wait-cycle counter; saturates at LIMIT because the FSM leaves the state then.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (!ready && (cnt_r != LIMIT)) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // ready on the limit cycle wins, so expiry requires ready low.
   assign expired = (MAX_WAIT != 0) && !ready && (cnt_r == LIMIT);

endmodule

// File: rtl/cpu_controller_mc.sv
// Multi-cycle control FSM for the 8-bit CPU.
// Sequences fetch/decode/operand/memory/execute phases, each memory access
// gated by mem_ready with a wait timeout; adds vectored interrupt entry,
// run/stop, illegal-opcode and timeout traps, and a retired-instruction count.
// Ports: clk, rst; ins (opcode from IR), run, mem_ready, irq;
// state, fetch, datapath enables, ROM/RAM strobes, irq_ack/irq_vec_sel,
// halted/trap_ill/trap_timeout status and instr_cnt.
module cpu_controller_mc
   import cpu_pkg::*;
#(
   parameter int OPW      = 4,
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [OPW-1:0]     ins,
   input  logic               run,
   input  logic               mem_ready,
   input  logic               irq,
   output logic [STATE_W-1:0] state,
   output logic [1:0]         fetch,
   output logic               PC_en,
   output logic               pc_in,
   output logic               ac_ena,
   output logic               write_r,
   output logic               read_r,
   output logic               im_int,
   output logic               ad_sel,
   output logic               rom_ena,
   output logic               rom_read,
   output logic               ram_ena,
   output logic               ram_read,
   output logic               ram_write,
   output logic               irq_ack,
   output logic               irq_vec_sel,
   output logic               halted,
   output logic               trap_ill,
   output logic               trap_timeout,
   output logic [CNT_W-1:0]   instr_cnt
);

   state_t           state_r;
   state_t           state_nx_s;
   state_t           retire_nx_s;
   logic [CNT_W-1:0] instr_cnt_r;
   logic             trap_ill_r;
   logic             trap_to_r;
   logic             retire_s;
   logic             goto_ill_s;
   logic             goto_to_s;
   logic             expired_s;
   logic             clear_s;
   logic             upper_bad_s;
   logic [3:0]       op_s;

   assign op_s = ins[3:0];

   generate
      if (OPW > 4) begin : g_upper
         assign upper_bad_s = |ins[OPW-1:4];
      end else begin : g_no_upper
         assign upper_bad_s = 1'b0;
      end
   endgenerate

   // Restart the wait count on every state change and outside wait states.
   assign clear_s = (state_nx_s != state_r) || !is_wait_state(state_r);

   mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear_s),
      .ready   (mem_ready),
      .expired (expired_s)
   );

   // State, retired-count and sticky trap-cause registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= S_IDLE;
         instr_cnt_r <= '0;
         trap_ill_r  <= 1'b0;
         trap_to_r   <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         if (retire_s) begin
            instr_cnt_r <= instr_cnt_r + CNT_W'(1);
         end else begin
            instr_cnt_r <= instr_cnt_r;
         end
         trap_ill_r  <= trap_ill_r | goto_ill_s;
         trap_to_r   <= trap_to_r | goto_to_s;
      end
   end

   // Next-state decode and combinational control strobes.
   always_comb begin
      state_nx_s  = state_r;
      retire_s    = 1'b0;
      goto_ill_s  = 1'b0;
      goto_to_s   = 1'b0;
      fetch       = FETCH_NONE;
      PC_en       = 1'b0;
      pc_in       = 1'b0;
      ac_ena      = 1'b0;
      write_r     = 1'b0;
      read_r      = 1'b0;
      im_int      = 1'b0;
      ad_sel      = 1'b0;
      rom_ena     = 1'b0;
      rom_read    = 1'b0;
      ram_ena     = 1'b0;
      ram_read    = 1'b0;
      ram_write   = 1'b0;
      irq_ack     = 1'b0;
      irq_vec_sel = 1'b0;
      halted      = 1'b0;
      // Retire priority: pending interrupt, then stop request, then next fetch.
      retire_nx_s = irq ? S_IRQ : (run ? S_FETCH : S_IDLE);

      case (state_r)
         S_IDLE: begin
            state_nx_s = run ? S_FETCH : S_IDLE;
         end
         S_FETCH: begin
            rom_ena  = 1'b1;
            rom_read = 1'b1;
            fetch    = FETCH_IR;
            if (mem_ready) begin
               state_nx_s = S_DECODE;
            end else if (expired_s) begin
               state_nx_s = S_TRAP;
               goto_to_s  = 1'b1;
            end else begin
               state_nx_s = S_FETCH;
            end
         end
         S_DECODE: begin
            PC_en = 1'b1;
            if (upper_bad_s) begin
               state_nx_s = S_TRAP;
               goto_ill_s = 1'b1;
            end else begin
               case (op_s)
                  OP_NOP: begin
                     retire_s   = 1'b1;
                     state_nx_s = retire_nx_s;
                  end
                  OP_HLT: state_nx_s = S_HALT;
                  OP_PRE, OP_ADD, OP_INC, OP_DEC: state_nx_s = S_EXEC;
                  OP_ADN, OP_CLR: begin
                     im_int     = 1'b1;
                     state_nx_s = S_EXEC;
                  end
                  OP_LDO, OP_LDA, OP_STO, OP_LDM, OP_JMP: state_nx_s = S_OPND;
                  default: begin
                     state_nx_s = S_TRAP;
                     goto_ill_s = 1'b1;
                  end
               endcase
            end
         end
         S_OPND: begin
            rom_ena  = 1'b1;
            rom_read = 1'b1;
            fetch    = FETCH_OPND;
            if (mem_ready) begin
               PC_en = 1'b1;
               case (op_s)
                  OP_LDO, OP_LDA: state_nx_s = S_MEMRD;
                  OP_STO:         state_nx_s = S_MEMWR;
                  OP_LDM:         state_nx_s = S_EXEC;
                  OP_JMP:         state_nx_s = S_JUMP;
                  default: begin
                     state_nx_s = S_TRAP;
                     goto_ill_s = 1'b1;
                  end
               endcase
            end else if (expired_s) begin
               state_nx_s = S_TRAP;
               goto_to_s  = 1'b1;
            end else begin
               state_nx_s = S_OPND;
            end
         end
         S_MEMRD: begin
            ad_sel = 1'b1;
            if (op_s == OP_LDO) begin
               rom_ena  = 1'b1;
               rom_read = 1'b1;
            end else begin
               ram_ena  = 1'b1;
               ram_read = 1'b1;
            end
            if (mem_ready) begin
               write_r    = 1'b1;
               ac_ena     = 1'b1;
               retire_s   = 1'b1;
               state_nx_s = retire_nx_s;
            end else if (expired_s) begin
               state_nx_s = S_TRAP;
               goto_to_s  = 1'b1;
            end else begin
               state_nx_s = S_MEMRD;
            end
         end
         S_MEMWR: begin
            ad_sel    = 1'b1;
            read_r    = 1'b1;
            ram_ena   = 1'b1;
            ram_write = 1'b1;
            if (mem_ready) begin
               retire_s   = 1'b1;
               state_nx_s = retire_nx_s;
            end else if (expired_s) begin
               state_nx_s = S_TRAP;
               goto_to_s  = 1'b1;
            end else begin
               state_nx_s = S_MEMWR;
            end
         end
         S_EXEC: begin
            ac_ena = 1'b1;
            if ((op_s == OP_PRE) || (op_s == OP_ADD)) begin
               read_r = 1'b1;
            end else if (op_s == OP_LDM) begin
               write_r  = 1'b1;
               rom_ena  = 1'b1;
               rom_read = 1'b1;
            end else begin
               read_r = 1'b0;
            end
            retire_s   = 1'b1;
            state_nx_s = retire_nx_s;
         end
         S_JUMP: begin
            pc_in      = 1'b1;
            PC_en      = 1'b1;
            retire_s   = 1'b1;
            state_nx_s = retire_nx_s;
         end
         S_IRQ: begin
            irq_ack     = 1'b1;
            irq_vec_sel = 1'b1;
            pc_in       = 1'b1;
            PC_en       = 1'b1;
            state_nx_s  = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            // The HLT instruction retires only when an interrupt wakes it.
            if (irq) begin
               retire_s   = 1'b1;
               state_nx_s = S_IRQ;
            end else if (!run) begin
               state_nx_s = S_IDLE;
            end else begin
               state_nx_s = S_HALT;
            end
         end
         S_TRAP: begin
            state_nx_s = S_TRAP;
         end
         default: begin
            state_nx_s = S_IDLE;
         end
      endcase
   end

   assign state        = state_r;
   assign trap_ill     = trap_ill_r;
   assign trap_timeout = trap_to_r;
   assign instr_cnt    = instr_cnt_r;

endmodule

// File: tb/tb_cpu_controller_mc.sv
module tb_cpu_controller_mc;
   import cpu_pkg::*;

   localparam int OPW      = 6;
   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = 2;

   localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_OPND = 3, ST_MEMRD = 4;
   localparam int ST_MEMWR = 5, ST_EXEC = 6, ST_JUMP = 7, ST_IRQ = 8, ST_HALT = 9, ST_TRAP = 10;

   logic             clk = 1'b0;
   logic             rst, run, mem_ready, irq;
   logic [OPW-1:0]   ins;
   logic [3:0]       state;
   logic [1:0]       fetch;
   logic             PC_en, pc_in, ac_ena, write_r, read_r, im_int, ad_sel;
   logic             rom_ena, rom_read, ram_ena, ram_read, ram_write;
   logic             irq_ack, irq_vec_sel, halted, trap_ill, trap_timeout;
   logic [CNT_W-1:0] instr_cnt;

   int ntests  = 0;
   int nfail   = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   cpu_controller_mc #(.OPW(OPW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .ins(ins), .run(run), .mem_ready(mem_ready), .irq(irq),
      .state(state), .fetch(fetch), .PC_en(PC_en), .pc_in(pc_in), .ac_ena(ac_ena),
      .write_r(write_r), .read_r(read_r), .im_int(im_int), .ad_sel(ad_sel),
      .rom_ena(rom_ena), .rom_read(rom_read), .ram_ena(ram_ena), .ram_read(ram_read),
      .ram_write(ram_write), .irq_ack(irq_ack), .irq_vec_sel(irq_vec_sel),
      .halted(halted), .trap_ill(trap_ill), .trap_timeout(trap_timeout),
      .instr_cnt(instr_cnt)
   );

   wire [16:0] ctrl_w = {fetch, PC_en, pc_in, ac_ena, write_r, read_r, im_int, ad_sel,
                         rom_ena, rom_read, ram_ena, ram_read, ram_write,
                         irq_ack, irq_vec_sel, halted};

   typedef struct packed { logic [3:0] st; logic rdy; } cyc_t;

   // Expected control word for one cycle, straight from the per-state output table.
   function automatic logic [16:0] exp_ctrl(input int st, input logic [OPW-1:0] op, input logic rdy);
      logic [1:0] fe;
      logic pce, pci, ac, wr, rd, im, ad, re, rr, mae, mar, maw, ack, vec, hlt;
      logic [3:0] o;
      o = op[3:0];
      {fe, pce, pci, ac, wr, rd, im, ad, re, rr, mae, mar, maw, ack, vec, hlt} = 17'd0;
      case (st)
         ST_FETCH:  begin re = 1'b1; rr = 1'b1; fe = 2'b01; end
         ST_DECODE: begin pce = 1'b1; im = (o == OP_ADN) || (o == OP_CLR); end
         ST_OPND:   begin re = 1'b1; rr = 1'b1; fe = 2'b10; pce = rdy; end
         ST_MEMRD: begin
            ad = 1'b1;
            if (o == OP_LDO) begin re = 1'b1; rr = 1'b1; end
            else begin mae = 1'b1; mar = 1'b1; end
            wr = rdy; ac = rdy;
         end
         ST_MEMWR: begin ad = 1'b1; rd = 1'b1; mae = 1'b1; maw = 1'b1; end
         ST_EXEC: begin
            ac = 1'b1;
            rd = (o == OP_PRE) || (o == OP_ADD);
            if (o == OP_LDM) begin wr = 1'b1; re = 1'b1; rr = 1'b1; end
         end
         ST_JUMP: begin pci = 1'b1; pce = 1'b1; end
         ST_IRQ:  begin ack = 1'b1; vec = 1'b1; pci = 1'b1; pce = 1'b1; end
         ST_HALT: hlt = 1'b1;
         default: hlt = 1'b0;
      endcase
      return {fe, pce, pci, ac, wr, rd, im, ad, re, rr, mae, mar, maw, ack, vec, hlt};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      ntests++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Assert reset mid-cycle, check outputs immediately, release with run as set by caller.
   task automatic do_reset();
      rst = 1'b1; irq = 1'b0; mem_ready = 1'b0;
      #1;
      exp_cnt = 0;
      chk("rst_state", state, ST_IDLE);
      chk("rst_ctrl", ctrl_w, 0);
      chk("rst_cnt", instr_cnt, 0);
      chk("rst_trap", {trap_ill, trap_timeout}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("idle_after_rst", state, ST_IDLE);
      @(posedge clk); #1;
   endtask

   // Run one instruction from its FETCH cycle. Latencies are wait cycles before
   // mem_ready on fetch/operand/data accesses; the expected cycle timeline is
   // built from the instruction class and then replayed against the DUT.
   task automatic do_instr(input logic [OPW-1:0] op, input int lf, input int lo, input int lm,
                           input int irq_at, input int run_drop_at, input int stop_after);
      cyc_t q[$];
      logic [3:0] o;
      bit retires;
      o = op[3:0];
      retires = 1'b1;
      for (int k = 0; k <= lf; k++) q.push_back({4'(ST_FETCH), (k == lf)});
      q.push_back({4'(ST_DECODE), 1'($urandom_range(0, 1))});
      if (((op >> 4) != 0) || (o inside {4'b1100, 4'b1101, 4'b1110}) || (o == OP_HLT)) begin
         retires = 1'b0;
      end else if (o inside {OP_PRE, OP_ADD, OP_INC, OP_DEC, OP_ADN, OP_CLR}) begin
         q.push_back({4'(ST_EXEC), 1'($urandom_range(0, 1))});
      end else if (o != OP_NOP) begin
         for (int k = 0; k <= lo; k++) q.push_back({4'(ST_OPND), (k == lo)});
         if (o inside {OP_LDO, OP_LDA})
            for (int k = 0; k <= lm; k++) q.push_back({4'(ST_MEMRD), (k == lm)});
         else if (o == OP_STO)
            for (int k = 0; k <= lm; k++) q.push_back({4'(ST_MEMWR), (k == lm)});
         else if (o == OP_LDM)
            q.push_back({4'(ST_EXEC), 1'($urandom_range(0, 1))});
         else
            q.push_back({4'(ST_JUMP), 1'($urandom_range(0, 1))});
      end
      foreach (q[i]) begin
         ins       = op;
         mem_ready = q[i].rdy;
         irq       = (irq_at >= 0) && (i >= irq_at);
         run       = !((run_drop_at >= 0) && (i >= run_drop_at));
         #2;
         chk("state", state, q[i].st);
         chk("ctrl", ctrl_w, exp_ctrl(q[i].st, op, q[i].rdy));
         chk("trap_flags", {trap_ill, trap_timeout}, 0);
         if (i == stop_after) return;
         @(posedge clk); #1;
      end
      if (retires) begin
         exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
         chk("instr_cnt", instr_cnt, exp_cnt);
      end
   endtask

   // One IRQ entry cycle; the source drops irq once acknowledged.
   task automatic irq_cycle();
      irq = 1'b0;
      #2;
      chk("irq_state", state, ST_IRQ);
      chk("irq_ctrl", ctrl_w, exp_ctrl(ST_IRQ, '0, 1'b0));
      @(posedge clk); #1;
      chk("irq_no_cnt", instr_cnt, exp_cnt);
   endtask

   // TRAP must hold with all strobes low whatever the inputs do.
   task automatic check_trap(input logic ill, input logic to);
      for (int k = 0; k < 5; k++) begin
         ins = OPW'($urandom); irq = 1'($urandom); mem_ready = 1'($urandom);
         #2;
         chk("trap_state", state, ST_TRAP);
         chk("trap_ctrl", ctrl_w, 0);
         chk("trap_cause", {trap_ill, trap_timeout}, {ill, to});
         chk("trap_cnt", instr_cnt, exp_cnt);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [3:0]     legal [12];
      logic [OPW-1:0] op;
      logic [OPW-1:0] bad [2];
      legal = '{OP_NOP, OP_LDO, OP_LDA, OP_STO, OP_PRE, OP_ADD,
                OP_LDM, OP_JMP, OP_INC, OP_DEC, OP_ADN, OP_CLR};
      rst = 1'b1; run = 1'b1; irq = 1'b0; mem_ready = 1'b0; ins = '0;
      do_reset();

      // Reset asserted in the middle of MEMRD aborts at once.
      do_instr({2'b00, OP_LDA}, 0, 0, 3, -1, -1, 4);
      do_reset();

      // LDA with 3 wait cycles on every access.
      do_instr({2'b00, OP_LDA}, 3, 3, 3, -1, -1, -1);

      // Random legal instructions and latencies; counter wraps at 4.
      for (int n = 0; n < 40; n++) begin
         op = {2'b00, legal[$urandom_range(0, 11)]};
         do_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), -1, -1, -1);
      end

      // irq raised during STO wait: STO completes, then IRQ entry.
      do_instr({2'b00, OP_STO}, 0, 1, 3, 5, -1, -1);
      irq_cycle();

      // irq and run=0 together at retire: IRQ wins.
      do_instr({2'b00, OP_INC}, 1, 0, 0, 2, 2, -1);
      irq_cycle();

      // run=0 mid-instruction: completes, then IDLE until run returns.
      do_instr({2'b00, OP_ADD}, 1, 0, 0, -1, 1, -1);
      #2;
      chk("stop_idle", state, ST_IDLE);
      chk("stop_ctrl", ctrl_w, 0);
      @(posedge clk); #1;
      chk("stop_idle_hold", state, ST_IDLE);
      run = 1'b1;
      @(posedge clk); #1;

      // HLT waits for irq; the wake-up retires the HLT.
      do_instr({2'b00, OP_HLT}, 0, 0, 0, -1, -1, -1);
      for (int k = 0; k < 3; k++) begin
         mem_ready = 1'($urandom);
         #2;
         chk("halt_state", state, ST_HALT);
         chk("halt_ctrl", ctrl_w, exp_ctrl(ST_HALT, '0, 1'b0));
         chk("halt_cnt", instr_cnt, exp_cnt);
         @(posedge clk); #1;
      end
      irq = 1'b1;
      #2;
      chk("halt_wake_state", state, ST_HALT);
      @(posedge clk); #1;
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      chk("halt_wake_cnt", instr_cnt, exp_cnt);
      irq_cycle();

      // HLT with run dropped goes to IDLE without retiring.
      do_instr({2'b00, OP_HLT}, 1, 0, 0, -1, -1, -1);
      run = 1'b0;
      #2;
      chk("halt_stop_state", state, ST_HALT);
      @(posedge clk); #1;
      chk("halt_to_idle", state, ST_IDLE);
      chk("halt_to_idle_cnt", instr_cnt, exp_cnt);
      run = 1'b1;
      @(posedge clk); #1;

      // mem_ready stuck low in FETCH: timeout after 4 wait cycles.
      for (int k = 0; k < MAX_WAIT; k++) begin
         mem_ready = 1'b0;
         #2;
         chk("to_fetch", state, ST_FETCH);
         @(posedge clk); #1;
      end
      check_trap(1'b0, 1'b1);
      do_reset();

      // mem_ready on the 4th wait cycle wins over the timeout.
      do_instr({2'b00, OP_NOP}, 3, 0, 0, -1, -1, -1);

      // Illegal opcodes: unassigned low code and nonzero upper bit.
      bad = '{6'b001101, 6'b010001};
      foreach (bad[b]) begin
         do_instr(bad[b], $urandom_range(0, 3), 0, 0, -1, -1, -1);
         check_trap(1'b1, 1'b0);
         run = 1'b1;
         do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   // Hard time bound so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/cpu_controller_mc.md
Name: cpu_controller_mc

Overview:
- Multi-cycle control FSM for the 8-bit CPU; parametrised successor of the fixed-timing controller.
- Decodes the same opcode set. Every ROM/RAM access is gated by a mem_ready handshake with configurable timeout.
- Adds vectored interrupt entry, run/stop control, an illegal-opcode/timeout trap and a retired-instruction counter.
- Sits between IR/PC/accumulator/register file and the ROM/RAM ports.

Parameters:
- OPW, 4, instruction opcode width (>=4). Low 4 bits are decoded; any nonzero upper bit is illegal.
- MAX_WAIT, 15, maximum cycles a wait state may hold without mem_ready. 0 disables the timeout.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ins  in  OPW  current opcode from IR
- run  in  1  1=execute, 0=stop at next instruction boundary
- mem_ready  in  1  ROM/RAM access complete this cycle
- irq  in  1  level interrupt request
- state  out  4  current state encoding
- fetch  out  2  01=load IR, 10=load operand, 00=none
- PC_en, pc_in, ac_ena, write_r, read_r, im_int, ad_sel  out  1 each  datapath enables
- rom_ena, rom_read, ram_ena, ram_read, ram_write  out  1 each  memory strobes
- irq_ack, irq_vec_sel  out  1 each  interrupt acknowledge / PC vector mux select
- halted, trap_ill, trap_timeout  out  1 each  status
- instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all control/status outputs 0; instr_cnt=0; wait counter=0.
  - Reset mid-instruction aborts immediately.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, OPND=3, MEMRD=4, MEMWR=5, EXEC=6, JUMP=7, IRQ=8, HALT=9, TRAP=10.
- Outputs are combinational from state/ins/mem_ready. Any undriven output is 0.
- IDLE: go to FETCH when run=1.
- FETCH:
  - Asserts rom_ena, rom_read, fetch=01.
  - Holds until mem_ready, then goes to DECODE.
- DECODE: PC_en=1 for exactly one cycle, then:
  - NOP -> retire.
  - HLT -> HALT.
  - PRE/ADD/INC/DEC/ADN/CLR -> EXEC. For ADN and CLR, im_int=1 in DECODE.
  - LDO/LDA/STO/LDM/JMP -> OPND.
  - Opcodes 1100-1110, or any upper bit set -> TRAP with trap_ill=1.
- OPND:
  - Asserts rom_ena, rom_read, fetch=10 until mem_ready; PC_en=1 on the ready cycle.
  - Then LDO/LDA -> MEMRD, STO -> MEMWR, LDM -> EXEC, JMP -> JUMP.
- MEMRD:
  - Asserts ad_sel=1. LDO uses rom_ena+rom_read; LDA uses ram_ena+ram_read.
  - On the mem_ready cycle, write_r=1 and ac_ena=1, then retire.
- MEMWR:
  - Asserts ad_sel, read_r, ram_ena.
  - ram_write=1 only while waiting and on the ready cycle; retire on mem_ready.
- EXEC: one cycle with ac_ena=1. Additionally:
  - PRE/ADD: read_r=1.
  - LDM: write_r=1, rom_ena=1, rom_read=1.
  - Then retire.
- JUMP: one cycle with pc_in=1, PC_en=1, then retire.
- Retire (transition out of a completing state):
  - instr_cnt increments by 1 in that cycle and wraps modulo 2^CNT_W.
  - Next state priority: irq=1 -> IRQ; else run=0 -> IDLE; else FETCH.
- IRQ:
  - One cycle with irq_ack=1, irq_vec_sel=1, pc_in=1, PC_en=1, then FETCH.
  - The source must drop irq after ack. A still-high irq is taken again at the next retire.
  - IRQ does not increment instr_cnt.
- HALT:
  - halted=1; all strobes 0.
  - irq=1 -> IRQ (wake-up). HLT retires on wake, so instr_cnt increments on exit.
  - run=0 -> IDLE.
- TRAP: sticky until rst. The trap flag stays 1; all strobes 0; instr_cnt frozen.
- Wait counter:
  - Cleared on entry to FETCH/OPND/MEMRD/MEMWR; increments each cycle with mem_ready=0.
  - When the count reaches MAX_WAIT with mem_ready still 0, next state is TRAP with trap_timeout=1.
  - If mem_ready and the limit coincide, mem_ready wins.
  - With MAX_WAIT=0 the timeout never fires.
- Simultaneous events:
  - irq mid-instruction is deferred to retire.
  - run=0 mid-instruction lets the instruction complete, then the FSM goes to IDLE.
  - irq and run=0 together at retire: IRQ wins.

Decomposition:
- Shared package cpu_pkg holds:
  - the 4-bit opcode constants NOP..HLT;
  - the state encoding constants and STATE_W=4;
  - the fetch codes.
- One sub-module, mem_wait_timer (params MAX_WAIT; inputs clear, ready; output expired), owns the wait counter.

Test Plan:
- Reset with rst=1 mid-MEMRD -> state=0 and all outputs 0 in the same cycle. After release with run=1, FETCH on the first edge.
- LDA with mem_ready delayed 3 cycles on each access -> FETCH 4 cycles, DECODE 1, OPND 4, MEMRD 4. write_r and ac_ena high only on the final MEMRD cycle; instr_cnt 0->1.
- MAX_WAIT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 wait cycles with trap_timeout=1. mem_ready arriving on cycle 4 instead goes to DECODE, no trap.
- irq raised during an STO wait -> STO completes. Next state is IRQ with irq_ack, pc_in, PC_en and irq_vec_sel for 1 cycle, then FETCH; instr_cnt incremented once.
- Opcode 1101, and with OPW=6 opcode 010001 -> TRAP with trap_ill=1; further ins and irq are ignored until rst.
- HLT then irq -> halted=1 until irq, then IRQ -> FETCH. With CNT_W=2, four retires wrap instr_cnt 3->0.
